bus_arbiter_rmux: RTL and testbench
===================================

# bus_arbiter_rmux

Bus front end that sits on the initiator side of the system address decoder. It arbitrates between two bus masters (m0: primary master, m1: secondary master), drives the shared slave-side bus from the granted master, and returns slave read data. Read data is selected using the decoder's `s0_sel`/`s1_sel` outputs, registered one cycle to match the one-cycle read latency of the memory (s0, 0x0000–0x07FF) and the factorial core (s1, 0x7000–0x71FF). It also flags accesses to unmapped addresses.

## Interface
Parameters:
- AW, 16, address width
- DW, 32, data width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 requests bus
- m0_wr  in  1  master 0 write (1) / read (0)
- m0_address  in  AW  master 0 address
- m0_dout  in  DW  master 0 write data
- m1_req, m1_wr, m1_address, m1_dout  in  1/1/AW/DW  same meaning for master 1
- m0_grant  out  1  master 0 owns bus (registered)
- m1_grant  out  1  master 1 owns bus (registered)
- s_address  out  AW  bus address from granted master (combinational)
- s_wr  out  1  bus write strobe from granted master, gated by its req
- s_din  out  DW  bus write data from granted master
- s0_sel, s1_sel  in  1  decoder selects for current s_address
- s0_dout, s1_dout  in  DW  slave read data, valid one cycle after address
- m_din  out  DW  read data returned to masters (registered select)
- bus_err  out  1  one-cycle pulse: previous cycle was an unmapped access

## Operation
- Arbiter FSM, two states, registered grant:
  - GNT_M0 (reset state; m0_grant=1, m1_grant=0): go to GNT_M1 when m0_req=0 and m1_req=1; otherwise stay.
  - GNT_M1 (m0_grant=0, m1_grant=1): stay while m1_req=1; otherwise return to GNT_M0.
  - Master 1 therefore holds the bus for as long as it requests it, with no preemption. Master 0 is the default owner.
  - Exactly one grant is high at all times.
- Bus mux, combinational from grant state:
  - s_address and s_din come from the granted master.
  - s_wr = granted master's wr AND granted master's req. A non-granted master never drives a write.
- Read-return path:
  - sel_d[1:0] <= {s1_sel, s0_sel} each clock.
  - m_din = s0_dout when sel_d=01, s1_dout when sel_d=10, 0 otherwise (00, or the illegal value 11).
- Error flag: bus_err <= granted_req AND !s0_sel AND !s1_sel. It is registered, and is high for one cycle per unmapped access cycle.

## Timing
- Reset (asynchronous assertion) drives:
  - state=GNT_M0, m0_grant=1, m1_grant=0
  - sel_d=00, m_din=0, bus_err=0
  - s_address/s_din/s_wr follow m0 inputs; s_wr=0 unless m0_req=1
- Grant latency: a request change is seen at edge N, and the new grant is visible after edge N. The granted master may issue on the cycle after its grant rises.
- Handover cycle: while the grant has not yet switched, the bus is driven by the previous owner. With req low, that owner's s_wr is 0, so no spurious write occurs.
- Simultaneous m0_req=1 and m1_req=1 in GNT_M0: m0 keeps the bus. In GNT_M1: m1 keeps the bus.
- Read latency: address presented in cycle N; m_din is valid in cycle N+1, from the slave selected in cycle N. It is unaffected by a grant change at edge N+1.
- Back-to-back reads across slaves (s0 then s1 on consecutive cycles) return s0 data then s1 data on consecutive cycles.
- bus_err is asserted in cycle N+1 for an unmapped access in cycle N. Idle cycles (granted_req=0) never flag.
- Reset asserted mid-transaction: all registered outputs clear immediately. The in-flight read returns m_din=0.

## Test plan
- Reset: assert reset with m1_req=1 → m0_grant=1, m1_grant=0, m_din=0, bus_err=0. After release with m0_req=0, m1_grant=1 one edge later.
- Handover: m1 holds the bus; drop m1_req while m0_req=1 → m0_grant=1 after the next edge. A later m1_req=1 while m0_req=1 → m0 keeps the grant.
- Write gating: in GNT_M0, m1_req=1 with m1_wr=1 and m0_req=0 → s_wr=0 during the handover cycle; s_wr=1 with s_address=m1_address after the grant.
- Read return: m0 reads 0x0004 (s0_dout=0x1234_5678), then 0x7000 (s1_dout=0x0000_0078) → m_din=0x12345678, then 0x00000078 on consecutive cycles.
- Unmapped access: m0 reads 0x0800, then 0x71FF, then 0x8000 → bus_err pulses for 0x0800 and 0x8000 only, with m_din=0 on those return cycles.
- Reset mid-read: issue a read to 0x7000 and assert reset before the return edge → m_din=0, and sel_d is cleared.

Source files
------------

// File: rtl/bus_arbiter_rmux.sv
// rtl/bus_arbiter_rmux.sv - two-master arbiter with bus mux, registered read-return select and unmapped-access flag
module bus_arbiter_rmux #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_address,
    input  logic [DW-1:0] m0_dout,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_address,
    input  logic [DW-1:0] m1_dout,
    output logic          m0_grant,
    output logic          m1_grant,
    output logic [AW-1:0] s_address,
    output logic          s_wr,
    output logic [DW-1:0] s_din,
    input  logic          s0_sel,
    input  logic          s1_sel,
    input  logic [DW-1:0] s0_dout,
    input  logic [DW-1:0] s1_dout,
    output logic [DW-1:0] m_din,
    output logic          bus_err
);

    typedef enum logic {
        GNT_M0 = 1'b0,
        GNT_M1 = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic       bus_err_q, bus_err_d;
    logic       granted_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= GNT_M0;
            sel_q     <= 2'b00;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            bus_err_q <= bus_err_d;
        end
    end

    // m1 takes the bus only when m0 is idle, then keeps it until it stops requesting.
    always_comb begin
        state_d  = state_q;
        m0_grant = 1'b1;
        m1_grant = 1'b0;
        case (state_q)
            GNT_M0: begin
                if (!m0_req && m1_req) state_d = GNT_M1;
            end
            GNT_M1: begin
                m0_grant = 1'b0;
                m1_grant = 1'b1;
                if (!m1_req) state_d = GNT_M0;
            end
            default: state_d = GNT_M0;
        endcase
    end

    always_comb begin
        s_address   = m0_address;
        s_din       = m0_dout;
        s_wr        = m0_wr & m0_req;
        granted_req = m0_req;
        if (state_q == GNT_M1) begin
            s_address   = m1_address;
            s_din       = m1_dout;
            s_wr        = m1_wr & m1_req;
            granted_req = m1_req;
        end
    end

    always_comb begin
        sel_d     = {s1_sel, s0_sel};
        bus_err_d = granted_req & ~s0_sel & ~s1_sel;
    end

    // Both selects at once is a decoder fault; return zero rather than OR the slaves.
    always_comb begin
        m_din = '0;
        case (sel_q)
            2'b01:   m_din = s0_dout;
            2'b10:   m_din = s1_dout;
            default: m_din = '0;
        endcase
    end

    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_bus_arbiter_rmux.sv
// tb/tb_bus_arbiter_rmux.sv - randomized and directed checks of bus_arbiter_rmux against a behavioural model
module tb_bus_arbiter_rmux;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_wr, m1_req, m1_wr;
    logic [AW-1:0] m0_address, m1_address;
    logic [DW-1:0] m0_dout, m1_dout;
    logic          m0_grant, m1_grant;
    logic [AW-1:0] s_address;
    logic          s_wr;
    logic [DW-1:0] s_din;
    logic          s0_sel, s1_sel;
    logic [DW-1:0] s0_dout, s1_dout;
    logic [DW-1:0] m_din;
    logic          bus_err;

    int checks = 0;
    int errors = 0;

    // Model: who owns the bus, which slave (0 none, 1 s0, 2 s1, 3 both) answered last cycle, last cycle's error.
    int   owner = 0;
    int   prev_region = 0;
    logic prev_err = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter_rmux #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_address(m0_address), .m0_dout(m0_dout),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_address(m1_address), .m1_dout(m1_dout),
        .m0_grant(m0_grant), .m1_grant(m1_grant),
        .s_address(s_address), .s_wr(s_wr), .s_din(s_din),
        .s0_sel(s0_sel), .s1_sel(s1_sel), .s0_dout(s0_dout), .s1_dout(s1_dout),
        .m_din(m_din), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at the falling edge, check after settling, then advance the model past the next rising edge.
    task automatic drive(input logic rst,
                         input logic r0, input logic w0, input logic [AW-1:0] a0,
                         input logic r1, input logic w1, input logic [AW-1:0] a1,
                         input logic both_sel);
        logic [AW-1:0] ea;
        logic [DW-1:0] ed, emd;
        logic          ew, ereq, in_s0, in_s1;
        @(negedge clk);
        reset = rst;
        m0_req = r0; m0_wr = w0; m0_address = a0; m0_dout = $urandom;
        m1_req = r1; m1_wr = w1; m1_address = a1; m1_dout = $urandom;
        s0_dout = $urandom;
        s1_dout = $urandom;
        if (rst) begin
            owner = 0;
            prev_region = 0;
            prev_err = 1'b0;
        end
        ea   = (owner == 1) ? a1 : a0;
        ed   = (owner == 1) ? m1_dout : m0_dout;
        ereq = (owner == 1) ? r1 : r0;
        ew   = ereq & ((owner == 1) ? w1 : w0);
        in_s0 = (int'(ea) <= 32'h07FF);
        in_s1 = (int'(ea) >= 32'h7000) && (int'(ea) <= 32'h71FF);
        s0_sel = in_s0 | both_sel;
        s1_sel = in_s1 | both_sel;
        emd = (prev_region == 1) ? s0_dout : (prev_region == 2) ? s1_dout : '0;
        #1;
        chk("m0_grant", 32'(m0_grant), 32'(owner == 0));
        chk("m1_grant", 32'(m1_grant), 32'(owner == 1));
        chk("s_address", 32'(s_address), 32'(ea));
        chk("s_din", s_din, ed);
        chk("s_wr", 32'(s_wr), 32'(ew));
        chk("m_din", m_din, emd);
        chk("bus_err", 32'(bus_err), 32'(prev_err));
        if (!rst) begin
            prev_region = (s0_sel ? 1 : 0) + (s1_sel ? 2 : 0);
            prev_err    = ereq & ~s0_sel & ~s1_sel;
            if (owner == 0) owner = (!r0 && r1) ? 1 : 0;
            else            owner = r1 ? 1 : 0;
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 3))
            0: return AW'($urandom_range(0, 32'h07FF));
            1: return AW'($urandom_range(32'h7000, 32'h71FF));
            2: return AW'($urandom_range(32'h0800, 32'h6FFF));
            default: return AW'($urandom_range(32'h71FE, 32'hFFFF));
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        m0_req = 0; m0_wr = 0; m0_address = '0; m0_dout = '0;
        m1_req = 0; m1_wr = 0; m1_address = '0; m1_dout = '0;
        s0_sel = 0; s1_sel = 0; s0_dout = '0; s1_dout = '0;

        // Reset held with m1 requesting, then release: m1 wins one edge later.
        drive(1, 0, 0, 16'h0000, 1, 0, 16'h7004, 0);
        drive(1, 0, 0, 16'h0000, 1, 0, 16'h7004, 0);
        drive(0, 0, 0, 16'h0000, 1, 0, 16'h7004, 0);
        drive(0, 1, 0, 16'h0010, 1, 1, 16'h0020, 0);
        // Handover back to m0, then m0 keeps the bus against a new m1 request.
        drive(0, 1, 0, 16'h0010, 0, 0, 16'h0020, 0);
        drive(0, 1, 0, 16'h0014, 1, 1, 16'h0024, 0);
        drive(0, 1, 0, 16'h0018, 1, 1, 16'h0028, 0);
        // Write gating across a handover to m1.
        drive(0, 0, 1, 16'h0030, 1, 1, 16'h0040, 0);
        drive(0, 0, 1, 16'h0030, 1, 1, 16'h0044, 0);
        drive(0, 0, 0, 16'h0030, 0, 0, 16'h0044, 0);
        // Back-to-back reads across slaves.
        drive(0, 1, 0, 16'h0004, 0, 0, 16'h0000, 0);
        drive(0, 1, 0, 16'h7000, 0, 0, 16'h0000, 0);
        drive(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);
        // Unmapped, mapped at the s1 boundary, unmapped.
        drive(0, 1, 0, 16'h0800, 0, 0, 16'h0000, 0);
        drive(0, 1, 0, 16'h71FF, 0, 0, 16'h0000, 0);
        drive(0, 1, 0, 16'h8000, 0, 0, 16'h0000, 0);
        drive(0, 0, 0, 16'h8000, 0, 0, 16'h0000, 0);
        // Idle cycle on an unmapped address must not flag.
        drive(0, 0, 0, 16'hFFFF, 0, 0, 16'h0000, 0);
        // Illegal simultaneous select returns zero.
        drive(0, 1, 0, 16'h0100, 0, 0, 16'h0000, 1);
        drive(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);
        // Reset lands while a read to s1 is in flight.
        drive(0, 1, 0, 16'h7000, 0, 0, 16'h0000, 0);
        drive(1, 1, 0, 16'h7000, 0, 0, 16'h0000, 0);
        drive(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  1'($urandom), 1'($urandom), rand_addr(),
                  1'($urandom), 1'($urandom), rand_addr(),
                  ($urandom_range(0, 49) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
